// File: rtl/or1300_bus_pkg.sv
// Shared bus-side definitions for the store buffer.
//   - busState_t   : bus master FSM state encodings
//   - BURST_SINGLE : burst size value for a single-beat transaction
//   - ENTRY_W      : width of one buffered store (address + data + byte enables)
//   - storeEntry_t : layout of one buffered store
package or1300_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_BEGIN = 3'd2,
    ST_DATA  = 3'd3,
    ST_END   = 3'd4,
    ST_ERR   = 3'd5
  } busState_t;

  localparam logic [7:0] BURST_SINGLE = 8'd0;
  localparam int         ENTRY_W      = 32 + 32 + 4;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] data;
    logic [3:0]  byteEnables;
  } storeEntry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// Register-array FIFO holding buffered stores.
// Ports:
//   clock, reset    : clock, synchronous active-low reset
//   push, pushEntry : allocate a new entry (ignored when full)
//   merge           : byte-merge pushEntry into the tail entry (no allocation)
//   pop             : retire the head entry
//   headEntry       : oldest entry
//   tailEntry       : youngest entry (merge candidate)
//   count, full     : occupancy
// Fullness is judged on the count at the start of the cycle, so a pop in the
// same cycle never makes room for a push.
module store_buffer_fifo
  import or1300_bus_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  storeEntry_t pushEntry,
  input  logic        merge,
  input  logic        pop,
  output storeEntry_t headEntry,
  output storeEntry_t tailEntry,
  output logic [PTR_W:0] count,
  output logic        full
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  storeEntry_t      entries [DEPTH];
  logic [PTR_W-1:0] rdPtr, wrPtr, tailPtr;
  logic             doPush, doPop;

  assign full      = (count == FULL_COUNT);
  assign doPush    = push && !full;
  assign doPop     = pop && (count != '0);
  assign tailPtr   = wrPtr - PTR_W'(1);
  assign headEntry = entries[rdPtr];
  assign tailEntry = entries[tailPtr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        entries[wrPtr] <= pushEntry;
        wrPtr          <= wrPtr + PTR_W'(1);
      end
      if (merge) begin
        for (int b = 0; b < 4; b++)
          if (pushEntry.byteEnables[b])
            entries[tailPtr].data[8*b +: 8] <= pushEntry.data[8*b +: 8];
        entries[tailPtr].byteEnables <= entries[tailPtr].byteEnables | pushEntry.byteEnables;
      end
      if (doPop) rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the memory stage and the shared bus.
// Buffers stores in a FIFO and drains each as a single-beat bus write:
// IDLE -> REQ -> BEGIN -> DATA -> END (or ERR on a slave error).
// Optional build macro STORE_BUFFER_COMBINE_EN: a push to the same word as the
// youngest entry byte-merges into it instead of allocating.
// Ports:
//   clock, reset                         : clock, synchronous active-low reset
//   pushStore/Address/Data/ByteEnables   : store from the memory stage
//   memorySync, syncStall                : sync stall while the buffer drains
//   bufferFull                           : push not accepted this cycle
//   requestBus, busAccessGranted         : arbitration
//   beginTransactionOut, addressDataOut, byteEnablesOut, readNotWriteOut,
//   burstSizeOut, dataValidOut, busyIn, endTransactionOut, busErrorIn : bus
//   writeError, writeErrorAddress        : imprecise abort report
//   empty                                : nothing queued and bus FSM idle
module store_buffer
  import or1300_bus_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pushStore,
  input  logic [31:0] pushAddress,
  input  logic [31:0] pushData,
  input  logic [3:0]  pushByteEnables,
  input  logic        memorySync,
  output logic        bufferFull,
  output logic        syncStall,
  output logic        requestBus,
  input  logic        busAccessGranted,
  output logic        beginTransactionOut,
  output logic [31:0] addressDataOut,
  output logic [3:0]  byteEnablesOut,
  output logic        readNotWriteOut,
  output logic [7:0]  burstSizeOut,
  output logic        dataValidOut,
  input  logic        busyIn,
  output logic        endTransactionOut,
  input  logic        busErrorIn,
  output logic        writeError,
  output logic [31:0] writeErrorAddress,
  output logic        empty
);

  busState_t      state, nextState;
  storeEntry_t    pushEntry, headEntry, tailEntry;
  logic [PTR_W:0] count;
  logic           full, popHead, errorTaken, mergeHit;
  logic           unusedBits;

  // Address is stored word-aligned so the bus side never sees bits [1:0].
  assign pushEntry  = '{address: {pushAddress[31:2], 2'b00},
                        data: pushData, byteEnables: pushByteEnables};
  assign unusedBits = ^{pushAddress[1:0], tailEntry};

`ifdef STORE_BUFFER_COMBINE_EN
  // The head is frozen once its address phase has gone out, so it can only
  // absorb a merge while it has not reached BEGIN/DATA.
  assign mergeHit = pushStore && (count != '0) &&
                    (tailEntry.address[31:2] == pushAddress[31:2]) &&
                    !((count == (PTR_W+1)'(1)) &&
                      (state == ST_BEGIN || state == ST_DATA));
`else
  assign mergeHit = 1'b0;
`endif

  store_buffer_fifo #(.DEPTH(DEPTH)) fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (pushStore && !mergeHit),
    .pushEntry (pushEntry),
    .merge     (mergeHit),
    .pop       (popHead),
    .headEntry (headEntry),
    .tailEntry (tailEntry),
    .count     (count),
    .full      (full)
  );

  assign bufferFull = full;
  assign empty      = (count == '0) && (state == ST_IDLE);
  assign syncStall  = memorySync && !empty;

  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState           = state;
    popHead             = 1'b0;
    errorTaken          = 1'b0;
    requestBus          = 1'b0;
    beginTransactionOut = 1'b0;
    addressDataOut      = '0;
    byteEnablesOut      = '0;
    readNotWriteOut     = 1'b0;
    burstSizeOut        = BURST_SINGLE;
    dataValidOut        = 1'b0;
    endTransactionOut   = 1'b0;
    unique case (state)
      ST_IDLE: if (count != '0) nextState = ST_REQ;
      ST_REQ: begin
        requestBus = 1'b1;
        if (busAccessGranted) nextState = ST_BEGIN;
      end
      ST_BEGIN: begin
        requestBus          = 1'b1;
        beginTransactionOut = 1'b1;
        addressDataOut      = headEntry.address;
        byteEnablesOut      = headEntry.byteEnables;
        if (busErrorIn) begin
          errorTaken = 1'b1;
          nextState  = ST_ERR;
        end else nextState = ST_DATA;
      end
      ST_DATA: begin
        requestBus     = 1'b1;
        dataValidOut   = 1'b1;
        addressDataOut = headEntry.data;
        if (busErrorIn) begin
          errorTaken = 1'b1;
          nextState  = ST_ERR;
        end else if (!busyIn) begin
          popHead   = 1'b1;
          nextState = ST_END;
        end
      end
      ST_END, ST_ERR: begin
        endTransactionOut = 1'b1;
        nextState         = ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
    // A failed entry is dropped, never retried.
    if (errorTaken) popHead = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      writeError        <= 1'b0;
      writeErrorAddress <= '0;
    end else begin
      writeError <= errorTaken;
      if (errorTaken) writeErrorAddress <= headEntry.address;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4).
module tb_store_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pushStore = 1'b0;
  logic [31:0] pushAddress = '0;
  logic [31:0] pushData = '0;
  logic [3:0]  pushByteEnables = '0;
  logic        memorySync = 1'b0;
  logic        bufferFull, syncStall, requestBus;
  logic        busAccessGranted = 1'b0;
  logic        beginTransactionOut;
  logic [31:0] addressDataOut;
  logic [3:0]  byteEnablesOut;
  logic        readNotWriteOut;
  logic [7:0]  burstSizeOut;
  logic        dataValidOut;
  logic        busyIn = 1'b0;
  logic        endTransactionOut;
  logic        busErrorIn = 1'b0;
  logic        writeError;
  logic [31:0] writeErrorAddress;
  logic        empty;

  store_buffer #(.DEPTH(4)) dut (
    .clock(clock), .reset(reset), .pushStore(pushStore), .pushAddress(pushAddress),
    .pushData(pushData), .pushByteEnables(pushByteEnables), .memorySync(memorySync),
    .bufferFull(bufferFull), .syncStall(syncStall), .requestBus(requestBus),
    .busAccessGranted(busAccessGranted), .beginTransactionOut(beginTransactionOut),
    .addressDataOut(addressDataOut), .byteEnablesOut(byteEnablesOut),
    .readNotWriteOut(readNotWriteOut), .burstSizeOut(burstSizeOut),
    .dataValidOut(dataValidOut), .busyIn(busyIn), .endTransactionOut(endTransactionOut),
    .busErrorIn(busErrorIn), .writeError(writeError), .writeErrorAddress(writeErrorAddress),
    .empty(empty)
  );

  always #5 clock = ~clock;

  int nTests = 0;
  int nFail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic pushOne(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    pushStore = 1'b1; pushAddress = a; pushData = d; pushByteEnables = be;
    step();
    pushStore = 1'b0;
  endtask

  task automatic waitBegin(input string tag);
    for (int i = 0; i < 20 && !beginTransactionOut; i++) step();
    chk({tag, " begin"}, {31'd0, beginTransactionOut}, 32'd1);
  endtask

  // One unstalled write: BEGIN, DATA, END.
  task automatic drainOne(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be);
    waitBegin(tag);
    chk({tag, " addr"}, addressDataOut, a);
    chk({tag, " be"}, {28'd0, byteEnablesOut}, {28'd0, be});
    step();
    chk({tag, " dvalid"}, {31'd0, dataValidOut}, 32'd1);
    chk({tag, " data"}, addressDataOut, d);
    step();
    chk({tag, " end"}, {31'd0, endTransactionOut}, 32'd1);
    chk({tag, " req drop"}, {31'd0, requestBus}, 32'd0);
  endtask

  logic [31:0] fa [5] = '{32'h1000_0003, 32'h1000_0004, 32'h2000_0008, 32'h3000_000C, 32'h4000_0100};
  logic [31:0] fx [5] = '{32'h1000_0000, 32'h1000_0004, 32'h2000_0008, 32'h3000_000C, 32'h4000_0100};
  logic [31:0] fd [5] = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333, 32'hA4A4_4444};
  logic [3:0]  fb [5] = '{4'hF, 4'h1, 4'h3, 4'hC, 4'h8};

  initial begin
    // Reset state
    step(); step();
    reset = 1'b1;
    chk("rst empty", {31'd0, empty}, 32'd1);
    chk("rst full", {31'd0, bufferFull}, 32'd0);
    chk("rst req", {31'd0, requestBus}, 32'd0);
    chk("rst errAddr", writeErrorAddress, 32'd0);
    chk("rst werr", {31'd0, writeError}, 32'd0);

    // Single store, immediate grant
    busAccessGranted = 1'b1;
    pushOne(32'h5000_0004, 32'hDEAD_BEEF, 4'hF);
    chk("s1 idle req", {31'd0, requestBus}, 32'd0);
    chk("s1 not empty", {31'd0, empty}, 32'd0);
    step();
    chk("s1 req", {31'd0, requestBus}, 32'd1);
    step();
    chk("s1 begin", {31'd0, beginTransactionOut}, 32'd1);
    chk("s1 addr", addressDataOut, 32'h5000_0004);
    chk("s1 be", {28'd0, byteEnablesOut}, 32'hF);
    chk("s1 rnw", {31'd0, readNotWriteOut}, 32'd0);
    chk("s1 burst", {24'd0, burstSizeOut}, 32'd0);
    step();
    chk("s1 dvalid", {31'd0, dataValidOut}, 32'd1);
    chk("s1 data", addressDataOut, 32'hDEAD_BEEF);
    chk("s1 req hold", {31'd0, requestBus}, 32'd1);
    step();
    chk("s1 end", {31'd0, endTransactionOut}, 32'd1);
    chk("s1 end req", {31'd0, requestBus}, 32'd0);
    step();
    chk("s1 empty", {31'd0, empty}, 32'd1);
    chk("s1 end low", {31'd0, endTransactionOut}, 32'd0);

    // Fill with grant low, fifth push held until a slot frees
    busAccessGranted = 1'b0;
    pushStore = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pushAddress = fa[i]; pushData = fd[i]; pushByteEnables = fb[i];
      step();
      chk($sformatf("fill full %0d", i), {31'd0, bufferFull}, (i == 3) ? 32'd1 : 32'd0);
    end
    pushAddress = fa[4]; pushData = fd[4]; pushByteEnables = fb[4];
    step();
    chk("full holds", {31'd0, bufferFull}, 32'd1);
    memorySync = 1'b1; #1;
    chk("sync stall", {31'd0, syncStall}, 32'd1);
    memorySync = 1'b0; #1;
    chk("sync clear", {31'd0, syncStall}, 32'd0);
    busAccessGranted = 1'b1;
    drainOne("fifo0", fx[0], fd[0], fb[0]);
    chk("slot freed", {31'd0, bufferFull}, 32'd0);
    step();
    pushStore = 1'b0;
    chk("refilled", {31'd0, bufferFull}, 32'd1);
    for (int i = 1; i < 5; i++) drainOne($sformatf("fifo%0d", i), fx[i], fd[i], fb[i]);
    step();
    chk("fifo empty", {31'd0, empty}, 32'd1);

    // Slave busy for 3 cycles in DATA
    pushOne(32'h0000_1000, 32'hB0B0_B0B0, 4'hF);
    pushOne(32'h0000_2000, 32'hB1B1_B1B1, 4'h6);
    waitBegin("busy");
    chk("busy addr", addressDataOut, 32'h0000_1000);
    busyIn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("busy dv %0d", k), {31'd0, dataValidOut}, 32'd1);
      chk($sformatf("busy data %0d", k), addressDataOut, 32'hB0B0_B0B0);
      if (k == 3) busyIn = 1'b0;
    end
    step();
    chk("busy end", {31'd0, endTransactionOut}, 32'd1);
    drainOne("busy next", 32'h0000_2000, 32'hB1B1_B1B1, 4'h6);
    step();
    chk("busy empty", {31'd0, empty}, 32'd1);

    // Bus error in DATA
    pushOne(32'h4000_0010, 32'hE0E0_E0E0, 4'hF);
    pushOne(32'h4000_0020, 32'hE1E1_E1E1, 4'h3);
    waitBegin("err");
    step();
    busErrorIn = 1'b1;
    step();
    busErrorIn = 1'b0;
    chk("err pulse", {31'd0, writeError}, 32'd1);
    chk("err addr", writeErrorAddress, 32'h4000_0010);
    chk("err end", {31'd0, endTransactionOut}, 32'd1);
    chk("err dv", {31'd0, dataValidOut}, 32'd0);
    step();
    chk("err pulse off", {31'd0, writeError}, 32'd0);
    chk("err addr hold", writeErrorAddress, 32'h4000_0010);
    drainOne("err next", 32'h4000_0020, 32'hE1E1_E1E1, 4'h3);
    step();
    chk("err empty", {31'd0, empty}, 32'd1);

`ifdef STORE_BUFFER_COMBINE_EN
    busAccessGranted = 1'b0;
    pushOne(32'h6000_0000, 32'h0000_0011, 4'b0001);
    pushOne(32'h6000_0000, 32'h0033_0000, 4'b0100);
    busAccessGranted = 1'b1;
    drainOne("merge", 32'h6000_0000, 32'h0033_0011, 4'b0101);
    step();
    chk("merge empty", {31'd0, empty}, 32'd1);
`endif

    // Reset mid-transaction with two entries queued
    pushOne(32'h7000_0000, 32'h7777_0000, 4'hF);
    pushOne(32'h7000_0004, 32'h7777_0004, 4'hF);
    waitBegin("mrst");
    step();
    chk("mrst in data", {31'd0, dataValidOut}, 32'd1);
    reset = 1'b0;
    step();
    chk("mrst req", {31'd0, requestBus}, 32'd0);
    chk("mrst dv", {31'd0, dataValidOut}, 32'd0);
    chk("mrst bt", {31'd0, beginTransactionOut}, 32'd0);
    chk("mrst et", {31'd0, endTransactionOut}, 32'd0);
    chk("mrst ad", addressDataOut, 32'd0);
    chk("mrst be", {28'd0, byteEnablesOut}, 32'd0);
    chk("mrst empty", {31'd0, empty}, 32'd1);
    chk("mrst full", {31'd0, bufferFull}, 32'd0);
    reset = 1'b1;
    step(); step();
    chk("mrst stays idle", {31'd0, requestBus}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write FIFO directly downstream of the memory stage, on the bus side.
- Absorbs uncached and write-through stores, then drains them as single-beat write transactions on the shared bus.
- The memory stage stalls only when the buffer is full, or on a memory sync while the buffer is non-empty.
- Bus write errors are reported back as an imprecise data abort.

Parameters:
- DEPTH, 4, number of store entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH), FIFO pointer width; derived, not overridden.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- pushStore  in  1  memory stage presents a store this cycle.
- pushAddress  in  32  word-aligned store address; bits [1:0] ignored.
- pushData  in  32  store data, already lane-aligned.
- pushByteEnables  in  4  active byte lanes.
- memorySync  in  1  sync instruction in the memory stage.
- bufferFull  out  1  no push accepted this cycle.
- syncStall  out  1  memorySync high and buffer not empty.
- requestBus  out  1  bus request.
- busAccessGranted  in  1  arbiter grant.
- beginTransactionOut  out  1  address phase strobe.
- addressDataOut  out  32  address in begin cycle, data in data cycle, else 0.
- byteEnablesOut  out  4  valid with beginTransactionOut, else 0.
- readNotWriteOut  out  1  always 0 when driving, else 0.
- burstSizeOut  out  8  always 8'd0 (single beat).
- dataValidOut  out  1  data beat strobe.
- busyIn  in  1  slave not ready; holds the data beat.
- endTransactionOut  out  1  closes the transaction.
- busErrorIn  in  1  slave error.
- writeError  out  1  one-cycle pulse on a failed entry.
- writeErrorAddress  out  32  address of the failed entry; holds until the next error.
- empty  out  1  no entries and FSM in IDLE.

Behaviour:
- Reset (reset==0 at a clock edge):
  - pointers and count go to 0; FSM goes to IDLE.
  - all bus outputs, writeError and writeErrorAddress are 0; empty=1; bufferFull=0.
  - an in-flight transaction is abandoned; its outputs are low the next cycle.
- Push:
  - accepted when pushStore=1 and count<DEPTH, evaluated at the start of the cycle.
  - a pop in the same cycle does not free space for that push.
  - the entry is visible to the FSM the following cycle (1-cycle minimum latency to requestBus).
  - bufferFull = (count==DEPTH), combinational from registers.
  - a push while full is ignored; the memory stage must hold it.
- Count arithmetic:
  - push only: count+1; pop only: count-1; both: count unchanged.
  - pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if count>0, go to REQ.
  - REQ: requestBus=1; on busAccessGranted go to BEGIN.
  - BEGIN: one cycle; beginTransactionOut=1, addressDataOut={addr[31:2],2'b00}, byteEnablesOut=entry BE; go to DATA.
  - DATA: dataValidOut=1, addressDataOut=data; stay while busyIn=1; when busyIn=0, pop the head and go to END.
  - END: endTransactionOut=1, requestBus drops; go to IDLE.
  - ERR: entered from BEGIN or DATA on busErrorIn=1. That cycle pops the head, pulses writeError and loads writeErrorAddress; ERR then drives endTransactionOut=1 for one cycle and goes to IDLE.
- requestBus is held from REQ through DATA.
- Minimum store-to-store spacing is 4 cycles after grant.
- syncStall = memorySync & ~empty.
- Entries drain strictly in FIFO order.

Optional Feature:
- Macro STORE_BUFFER_COMBINE_EN enables write combining.
- With it: a push whose word address equals the tail (youngest) entry, and that entry is not the head currently in BEGIN/DATA, merges into the tail. Data is byte-merged per enable and byteEnables are ORed; count does not change, and a merge is allowed even when full.
- Without it: every push allocates a new entry.

Decomposition:
- Shared package or1300_bus_pkg holds:
  - FSM state encodings;
  - a BURST_SINGLE=8'd0 constant;
  - the entry width constant (32+32+4).
- One sub-module, store_buffer_fifo: register-array FIFO with push/pop/count and the tail-merge port. The bus FSM stays in the top.

Test Plan:
- Reset with 2 entries queued and the FSM in DATA: all bus outputs 0 the next cycle; empty=1.
- Push addr 0x5000_0004, data 0xDEADBEEF, BE 4'hF; grant immediately:
  - begin cycle shows 0x5000_0004;
  - next cycle dataValid with 0xDEADBEEF;
  - then endTransaction; empty=1 by cycle 5.
- Push 5 stores with grant held low (DEPTH=4): bufferFull=1 after the 4th; the 5th is ignored until a pop; all 4 drain in order.
- busyIn=1 for 3 cycles in DATA: dataValidOut and data held 3 extra cycles; exactly one pop.
- busErrorIn in DATA for address 0x4000_0010: writeError pulses once; writeErrorAddress=0x4000_0010; the next entry still drains.
- With STORE_BUFFER_COMBINE_EN: push BE 4'b0001 data 0x11, then BE 4'b0100 data 0x00330000 to the same word. Expect one entry with BE 4'b0101 and data 0x00330011.
